// File: rtl/ahb_bridge_pkg.sv
// Shared encodings, address map and transaction layout for the AHB side of the AHB2APB bridge.
package ahb_bridge_pkg;

  // htrans encodings; bit 1 set marks a real (NONSEQ/SEQ) transfer.
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  // hres encodings.
  localparam logic [1:0] HresOkay  = 2'b00;
  localparam logic [1:0] HresError = 2'b01;

  // APB slave address map, one 64 MiB window per slave.
  localparam logic [31:0] Slv0Base  = 32'h8000_0000;
  localparam logic [31:0] Slv0Limit = 32'h83FF_FFFF;
  localparam logic [31:0] Slv1Base  = 32'h8400_0000;
  localparam logic [31:0] Slv1Limit = 32'h87FF_FFFF;
  localparam logic [31:0] Slv2Base  = 32'h8800_0000;
  localparam logic [31:0] Slv2Limit = 32'h8BFF_FFFF;

  localparam int unsigned SizeW = 3;
  localparam int unsigned SelW  = 3;

  // AHB-side transfer FSM.
  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWstall,
    StRwait,
    StRdone,
    StErr1,
    StErr2
  } ahb_state_e;

  // Posted entry layout, MSB first: {write, addr, wdata, size, sel}.
  function automatic int unsigned txn_entry_w(input int unsigned addr_w,
                                              input int unsigned data_w);
    return 1 + addr_w + data_w + SizeW + SelW;
  endfunction

endpackage

// File: rtl/ahb_txn_fifo.sv
// Count-based synchronous FIFO holding posted AHB transactions for the APB controller.
module ahb_txn_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     hclk,
  input  logic                     hresten,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  // Full/empty come from the registered count, so a pop never makes room for a same-cycle push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign pop_data = mem[rptr_q];
  assign count    = count_q;

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge hclk) begin
    if (do_push) begin
      mem[wptr_q] <= push_data;
    end
  end

  // Wrapping pointers and occupancy count.
  always_ff @(posedge hclk or negedge hresten) begin
    if (!hresten) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB2APB bridge: decodes and registers AHB transfers, posts them
// into a small FIFO for the APB controller and returns hreadyout/hres/hrdata to the master.
module ahb_slave_interface
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              hclk,
  input  logic              hresten,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic [1:0]        hres,
  output logic [DATA_W-1:0] hrdata,
  output logic              txn_valid,
  input  logic              txn_ready,
  output logic              txn_write,
  output logic [ADDR_W-1:0] txn_addr,
  output logic [DATA_W-1:0] txn_wdata,
  output logic [2:0]        txn_size,
  output logic [2:0]        txn_sel,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int unsigned EntryW = txn_entry_w(ADDR_W, DATA_W);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

  ahb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [SizeW-1:0]  size_q;
  logic [SelW-1:0]   sel_q;
  logic              rd_pushed_q, rd_pushed_d;
  logic [1:0]        hres_q;
  logic [DATA_W-1:0] hrdata_q;

  logic              accept;
  logic              push;
  logic [SelW-1:0]   haddr_sel;
  logic [DATA_W-1:0] push_wdata;
  logic [EntryW-1:0] push_entry, head_entry;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   unused_fifo_count;
  logic              unused_htrans0;

  assign unused_htrans0 = htrans[0];

  function automatic logic [SelW-1:0] decode_sel(input logic [ADDR_W-1:0] a);
    logic [SelW-1:0] s;
    s = '0;
    if (a >= ADDR_W'(Slv0Base) && a <= ADDR_W'(Slv0Limit)) s = 3'b001;
    if (a >= ADDR_W'(Slv1Base) && a <= ADDR_W'(Slv1Limit)) s = 3'b010;
    if (a >= ADDR_W'(Slv2Base) && a <= ADDR_W'(Slv2Limit)) s = 3'b100;
    return s;
  endfunction

  assign haddr_sel = decode_sel(haddr);
  assign accept    = hreadyout & hreadyin & htrans[1];

  // Reads carry no data toward APB; keep the field clean.
  assign push_wdata = write_q ? hwdata : '0;
  assign push_entry = {write_q, addr_q, push_wdata, size_q, sel_q};

  assign {txn_write, txn_addr, txn_wdata, txn_size, txn_sel} = head_entry;
  assign txn_valid = ~fifo_empty;
  assign hres      = hres_q;
  assign hrdata    = hrdata_q;

  // Wait-state decode: data phases that cannot complete this cycle hold hreadyout low.
  always_comb begin
    case (state_q)
      StWdata, StWstall: hreadyout = ~fifo_full;
      StRwait, StErr1:   hreadyout = 1'b0;
      default:           hreadyout = 1'b1;
    endcase
  end

  // Next-state, FIFO push and read-posted tracking.
  always_comb begin
    logic follow;
    state_d     = state_q;
    rd_pushed_d = rd_pushed_q;
    push        = 1'b0;
    follow      = 1'b0;
    case (state_q)
      StIdle, StRdone, StErr2: follow = 1'b1;
      StWdata, StWstall: begin
        if (fifo_full) begin
          state_d = StWstall;
        end else begin
          push   = 1'b1;
          follow = 1'b1;
        end
      end
      StRwait: begin
        if (!rd_pushed_q && !fifo_full) begin
          push        = 1'b1;
          rd_pushed_d = 1'b1;
        end
        // Read data can only answer a read the APB side has already been given.
        if (rd_pushed_q && rd_valid) begin
          state_d = StRdone;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    // Any cycle with hreadyout high may start the next pipelined transfer.
    if (follow) begin
      rd_pushed_d = 1'b0;
      if (!accept) begin
        state_d = StIdle;
      end else if (haddr_sel == '0) begin
        state_d = StErr1;
      end else if (hwrite) begin
        state_d = StWdata;
      end else begin
        state_d = StRwait;
      end
    end
  end

  // FSM state, latched address phase and registered responses.
  always_ff @(posedge hclk or negedge hresten) begin
    if (!hresten) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      sel_q       <= '0;
      rd_pushed_q <= 1'b0;
      hres_q      <= HresOkay;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_pushed_q <= rd_pushed_d;
      hres_q      <= (state_d == StErr1 || state_d == StErr2) ? HresError : HresOkay;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        size_q  <= hsize;
        sel_q   <= haddr_sel;
      end
      if (state_q == StRwait && state_d == StRdone) begin
        hrdata_q <= rd_data;
      end
    end
  end

  ahb_txn_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hclk      (hclk),
    .hresten   (hresten),
    .push      (push),
    .push_data (push_entry),
    .pop       (txn_ready),
    .pop_data  (head_entry),
    .count     (unused_fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/ahb_slave_interface.md
Name: ahb_slave_interface

Overview:
AHB-side front end of the AHB2APB bridge, directly downstream of the AHB master interface. It decodes and registers AHB address and data phases. Decoded transfers are posted into a small transaction FIFO that the APB controller drains. The block drives hreadyout, hres and hrdata back to the master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
FIFO_DEPTH, 2, posted-transaction entries; power of two, at least 2

Ports:
hclk  in  1  bridge clock, rising edge
hresten  in  1  asynchronous active-low reset
hwrite  in  1  transfer direction, 1 = write
hreadyin  in  1  master ready; address phase valid only when high
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  in  3  transfer size; carried through unchanged
haddr  in  ADDR_W  transfer address
hwdata  in  DATA_W  write data, valid in data phase
hreadyout  out  1  slave ready; low inserts wait states
hres  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_W  read data
txn_valid  out  1  FIFO head valid toward APB controller
txn_ready  in  1  APB controller pops head
txn_write, txn_addr, txn_wdata, txn_size, txn_sel  out  1/ADDR_W/DATA_W/3/3  head fields; txn_sel is one-hot slave select
rd_valid  in  1  one-cycle pulse: APB read data available
rd_data  in  DATA_W  APB read data

Behaviour:
- Reset (hresten=0, asynchronous) forces:
  - hreadyout=1, hres=00, hrdata=0, txn_valid=0.
  - FIFO empty, FSM in IDLE, pending address regs 0.
  - A reset mid-transfer discards all in-flight and posted entries.
- Address-phase accept: hreadyout=1 && hreadyin=1 && htrans[1]=1.
  - On accept, latch haddr, hwrite, hsize and the decoded sel.
  - IDLE/BUSY transfers cause no state change and get a zero-wait OKAY.
- Address decode:
  - 0x8000_0000-0x83FF_FFFF gives sel=001.
  - 0x8400_0000-0x87FF_FFFF gives sel=010.
  - 0x8800_0000-0x8BFF_FFFF gives sel=100.
  - Any other address gives sel=000, which produces an ERROR response.
- FSM states: IDLE, WDATA, WSTALL, RWAIT, RDONE, ERR1, ERR2. Pipelined: a new accept may occur in any cycle where hreadyout=1.
- IDLE: hreadyout=1, hres=00.
  - Accepted valid write goes to WDATA.
  - Accepted valid read goes to RWAIT.
  - Invalid address goes to ERR1.
- WDATA: hwdata is captured this cycle.
  - If FIFO count < FIFO_DEPTH: push {1, addr, hwdata, size, sel}; hreadyout=1; next state follows the accept rules, else IDLE.
  - If the FIFO is full: hreadyout=0 and go to WSTALL.
- WSTALL: hreadyout=0 while the FIFO is full; the master holds hwdata. When count drops below full, push and proceed as in WDATA.
- RWAIT: hreadyout=0.
  - The read is pushed once the FIFO has room. Push order equals accept order, so reads never overtake posted writes.
  - On rd_valid, register rd_data into hrdata and go to RDONE.
- RDONE: hreadyout=1, hrdata holds the value; then follow the accept rules.
- Error response:
  - ERR1: hreadyout=0, hres=01.
  - ERR2: hreadyout=1, hres=01.
  - Then hres returns to 00. Nothing is pushed for an errored transfer.
- FIFO:
  - Count-based with wrapping read/write pointers; no bypass.
  - txn_valid = (count != 0); pop when txn_valid && txn_ready.
  - Push is legal only when count < FIFO_DEPTH, evaluated on the registered count. Push and pop in the same cycle leave count unchanged.
  - Pop on empty is ignored.
- A rd_valid arriving outside RWAIT is ignored.
- hrdata changes only on entry to RDONE.

Decomposition:
- Package ahb_bridge_pkg holds:
  - htrans encodings and hres encodings (OKAY/ERROR).
  - Slave base/limit address constants.
  - FSM state encoding.
  - The transaction entry width and layout.
- Sub-module ahb_txn_fifo: a parameterised synchronous FIFO with push/pop/count/full/empty, clocked by hclk and reset by hresten.

Test Plan:
1. Single write, txn_ready=1:
   - Stimulus: NONSEQ write to 0x8000_0001, hwdata 0x0000_1122 in the data phase.
   - Required: hreadyout stays 1; txn_valid=1 for one cycle after the data phase with addr 0x8000_0001, wdata 0x0000_1122, write=1, sel=001.
2. Single read of 0x8000_0001:
   - Stimulus: txn_valid with write=0 is accepted; three cycles later rd_valid with rd_data=0xDEAD_BEEF.
   - Required: hreadyout=0 until the cycle after rd_valid, then hreadyout=1 with hrdata=0xDEAD_BEEF.
3. Three back-to-back writes with txn_ready=0:
   - Required: the first two are accepted with zero wait; the third data phase holds hreadyout=0.
   - Then one txn_ready pulse: the third write is pushed the next cycle and hreadyout returns to 1.
4. Write to 0x9000_0000:
   - Required: hres=01 with hreadyout=0, then hres=01 with hreadyout=1, then OKAY; txn_valid never asserts.
5. htrans=IDLE, then BUSY, with hreadyin=1:
   - Required: hreadyout=1, hres=00, no FIFO push.
   - Also: NONSEQ with hreadyin=0 is not accepted.
6. Reset mid-operation:
   - Stimulus: hresten pulled low during RWAIT with 2 posted entries.
   - Required: immediately hreadyout=1, hres=00, hrdata=0, txn_valid=0; after release a fresh write behaves as in scenario 1.
